// File: rtl/alarme_kdn_if.sv
// alarme_kdn_if: button/control inputs and indicator outputs of the K-of-N alarm.
// master drives buttons and controls; slave (the alarm core) drives status outputs.
interface alarme_kdn_if #(
    parameter int N_BOTOES = 3
) ();
    logic [N_BOTOES-1:0]         botoes;
    logic                        armar;
    logic                        desarmar;
    logic                        ack;
    logic [$clog2(N_BOTOES+1)-1:0] contagem;
    logic [1:0]                  estado;
    logic                        led;
    logic                        sirene;

    modport master (
        output botoes, armar, desarmar, ack,
        input  contagem, estado, led, sirene
    );

    modport slave (
        input  botoes, armar, desarmar, ack,
        output contagem, estado, led, sirene
    );
endinterface

// File: rtl/alarme_kdn.sv
// alarme_kdn: K-of-N voting alarm. Raw buttons are synchronised, debounced and
// counted; when armed and at least K_MIN buttons are held, an entry delay runs
// and then the alarm latches until acknowledged (trigger false) or disarmed.
// Optional macro ALARME_PISCA_EN: LED blinks with half-period PISCA_CICLOS in ALARME.
module alarme_kdn #(
    parameter int N_BOTOES      = 3,
    parameter int K_MIN         = 2,
    parameter int DEB_CICLOS    = 4,
    parameter int ATRASO_CICLOS = 8,
    parameter int PISCA_CICLOS  = 4
) (
    input  logic         clk,
    input  logic         rst,
    alarme_kdn_if.slave  bus
);

    localparam int CW = $clog2(N_BOTOES + 1);
    localparam int DW = $clog2(DEB_CICLOS + 1);
    localparam int TW = (ATRASO_CICLOS > 1) ? $clog2(ATRASO_CICLOS) : 1;

    localparam logic [DW-1:0] DEB_FIM    = DW'(DEB_CICLOS - 1);
    localparam logic [TW-1:0] ATRASO_INI = TW'(ATRASO_CICLOS - 1);
    localparam logic [CW-1:0] K_LIM      = CW'(K_MIN);

    typedef enum logic [1:0] {
        DESARMADO  = 2'd0,
        ARMADO     = 2'd1,
        PRE_ALARME = 2'd2,
        ALARME     = 2'd3
    } estado_t;

    logic [N_BOTOES-1:0] sync1_q, sync1_d;
    logic [N_BOTOES-1:0] sync2_q, sync2_d;
    logic [N_BOTOES-1:0] deb_q, deb_d;
    logic [DW-1:0]       deb_cnt_q [N_BOTOES];
    logic [DW-1:0]       deb_cnt_d [N_BOTOES];

    logic [CW-1:0]       contagem_q, contagem_d;
    estado_t             estado_q, estado_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                led_q, led_d;
    logic                sirene_q, sirene_d;
    logic                gatilho;

`ifdef ALARME_PISCA_EN
    localparam int BW = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;
    localparam logic [BW-1:0] PISCA_FIM = BW'(PISCA_CICLOS - 1);
    logic [BW-1:0]       pisca_q, pisca_d;
`endif

    // Synchroniser shift and per-input debounce counters
    always_comb begin
        sync1_d = bus.botoes;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int unsigned i = 0; i < N_BOTOES; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_FIM) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Popcount of debounced buttons; cannot exceed N_BOTOES so never wraps
    always_comb begin
        contagem_d = '0;
        for (int unsigned i = 0; i < N_BOTOES; i++) begin
            contagem_d = contagem_d + CW'(deb_q[i]);
        end
    end

    assign gatilho = (contagem_q >= K_LIM);

    // Input path registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            contagem_q <= '0;
            for (int unsigned i = 0; i < N_BOTOES; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            contagem_q <= contagem_d;
            for (int unsigned i = 0; i < N_BOTOES; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // FSM state and entry-delay timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= DESARMADO;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    // Next state: desarmar has priority over everything else
    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        if (bus.desarmar) begin
            estado_d = DESARMADO;
            timer_d  = '0;
        end else begin
            case (estado_q)
                DESARMADO: begin
                    if (bus.armar) estado_d = ARMADO;
                end
                ARMADO: begin
                    if (gatilho) begin
                        estado_d = PRE_ALARME;
                        timer_d  = ATRASO_INI;
                    end
                end
                PRE_ALARME: begin
                    if (timer_q == '0) estado_d = ALARME;
                    else               timer_d  = timer_q - TW'(1);
                end
                ALARME: begin
                    if (bus.ack && !gatilho) estado_d = ARMADO;
                end
                default: estado_d = DESARMADO;
            endcase
        end
    end

    // Outputs decoded from the next state so they move on the same edge as estado
    always_comb begin
        sirene_d = (estado_d == ALARME);
`ifdef ALARME_PISCA_EN
        pisca_d = '0;
        if (estado_d == ALARME) begin
            if (estado_q != ALARME) begin
                led_d = 1'b1;
            end else if (pisca_q == PISCA_FIM) begin
                led_d = ~led_q;
            end else begin
                led_d   = led_q;
                pisca_d = pisca_q + BW'(1);
            end
        end else begin
            led_d = (estado_d == PRE_ALARME);
        end
`else
        led_d = (estado_d == PRE_ALARME) || (estado_d == ALARME);
`endif
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= 1'b0;
            sirene_q <= 1'b0;
`ifdef ALARME_PISCA_EN
            pisca_q  <= '0;
`endif
        end else begin
            led_q    <= led_d;
            sirene_q <= sirene_d;
`ifdef ALARME_PISCA_EN
            pisca_q  <= pisca_d;
`endif
        end
    end

    assign bus.contagem = contagem_q;
    assign bus.estado   = estado_q;
    assign bus.led      = led_q;
    assign bus.sirene   = sirene_q;

endmodule

// File: tb/tb_alarme_kdn.sv
// tb_alarme_kdn: directed test of alarme_kdn with default parameters.
module tb_alarme_kdn;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    alarme_kdn_if #(.N_BOTOES(3)) bus ();

    alarme_kdn #(
        .N_BOTOES(3),
        .K_MIN(2),
        .DEB_CICLOS(4),
        .ATRASO_CICLOS(8),
        .PISCA_CICLOS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit before sampling/driving
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_led;
        int max_cnt;
        bit got_zero;

        bus.botoes   = '0;
        bus.armar    = 1'b0;
        bus.desarmar = 1'b0;
        bus.ack      = 1'b0;
        rst          = 1'b1;
        tick(2);
        check("rst_estado",   int'(bus.estado),   0);
        check("rst_contagem", int'(bus.contagem), 0);
        check("rst_led",      int'(bus.led),      0);
        check("rst_sirene",   int'(bus.sirene),   0);
        rst = 1'b0;
        tick(1);

        // arm for one cycle
        bus.armar = 1'b1;
        tick(1);
        bus.armar = 1'b0;
        check("arm_estado", int'(bus.estado), 1);
        check("arm_led",    int'(bus.led),    0);
        check("arm_sirene", int'(bus.sirene), 0);

        // one button: below K_MIN, never triggers; contagem appears at E+6
        bus.botoes = 3'b001;
        tick(6);
        check("one_cnt_e5", int'(bus.contagem), 0);
        tick(1);
        check("one_cnt_e6", int'(bus.contagem), 1);
        tick(20);
        check("one_estado_hold", int'(bus.estado), 1);

        // two buttons: trigger, 8-cycle entry delay, alarm
        bus.botoes = 3'b011;
        tick(6);
        check("two_cnt_e5", int'(bus.contagem), 1);
        tick(1);
        check("two_cnt_e6",    int'(bus.contagem), 2);
        check("two_estado_e6", int'(bus.estado),   1);
        tick(1);
        check("pre_estado", int'(bus.estado), 2);
        check("pre_led",    int'(bus.led),    1);
        check("pre_sirene", int'(bus.sirene), 0);
        tick(7);
        check("pre_last_cycle", int'(bus.estado), 2);
        tick(1);
        check("alarm_estado", int'(bus.estado), 3);
        check("alarm_sirene", int'(bus.sirene), 1);

        // led over 12 cycles from the entry edge
        for (int i = 0; i < 12; i++) begin
`ifdef ALARME_PISCA_EN
            exp_led = ((i / 4) % 2 == 0) ? 1 : 0;
`else
            exp_led = 1;
`endif
            check($sformatf("alarm_led_%0d", i), int'(bus.led), exp_led);
            tick(1);
        end

        // ack with trigger still true is ignored
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
        check("ack_ignored", int'(bus.estado), 3);

        // release, wait (bounded) for contagem=0, then ack
        bus.botoes = 3'b000;
        got_zero = 1'b0;
        for (int i = 0; i < 20 && !got_zero; i++) begin
            tick(1);
            if (bus.contagem == 0) got_zero = 1'b1;
        end
        check("release_cnt", int'(got_zero), 1);
        check("release_still_alarm", int'(bus.estado), 3);
        bus.ack = 1'b1;
        tick(1);
        bus.ack = 1'b0;
        check("ack_estado", int'(bus.estado), 1);
        check("ack_sirene", int'(bus.sirene), 0);
        check("ack_led",    int'(bus.led),    0);

        // 3-cycle glitch on all buttons is rejected by debounce
        bus.botoes = 3'b111;
        tick(3);
        bus.botoes = 3'b000;
        max_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (int'(bus.contagem) > max_cnt) max_cnt = int'(bus.contagem);
        end
        check("glitch_cnt",    max_cnt,            0);
        check("glitch_estado", int'(bus.estado),   1);

        // into PRE_ALARME, then desarmar+armar together
        bus.botoes = 3'b011;
        tick(8);
        check("pre2_estado", int'(bus.estado), 2);
        bus.desarmar = 1'b1;
        bus.armar    = 1'b1;
        tick(1);
        bus.desarmar = 1'b0;
        check("dis_estado", int'(bus.estado), 0);
        check("dis_led",    int'(bus.led),    0);
        // armar still held re-arms on the next edge
        tick(1);
        check("rearm_estado", int'(bus.estado), 1);
        bus.armar = 1'b0;
        // buttons still held: immediate trigger, full delay again (timer reloaded)
        tick(1);
        check("pre3_estado", int'(bus.estado), 2);
        tick(7);
        check("pre3_last", int'(bus.estado), 2);
        tick(1);
        check("alarm2_estado", int'(bus.estado), 3);

        // reset in ALARME, armar held during reset is ignored
        rst       = 1'b1;
        bus.armar = 1'b1;
        bus.ack   = 1'b1;
        tick(1);
        check("rst2_estado",   int'(bus.estado),   0);
        check("rst2_led",      int'(bus.led),      0);
        check("rst2_sirene",   int'(bus.sirene),   0);
        check("rst2_contagem", int'(bus.contagem), 0);
        tick(1);
        check("rst2_hold", int'(bus.estado), 0);
        rst       = 1'b0;
        bus.armar = 1'b0;
        bus.ack   = 1'b0;
        tick(1);
        check("post_rst_estado", int'(bus.estado), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alarme_kdn.md
# alarme_kdn

Parametrised K-of-N voting alarm with per-input debounce, arm/disarm control, entry delay and latched alarm with acknowledge. Raw push-button inputs are synchronised, debounced and counted. When at least K_MIN buttons are held while armed, an entry-delay timer starts; on expiry the alarm latches until acknowledged or disarmed. Sits between the board's button pins and the LED/buzzer outputs and replaces the fixed 3-input, 2-vote combinational alarm.

## Interface
- N_BOTOES, 3: number of button inputs; legal range 2..16.
- K_MIN, 2: votes needed to trigger; legal range 1..N_BOTOES.
- DEB_CICLOS, 4: consecutive stable cycles for a debounced bit to change; minimum 1.
- ATRASO_CICLOS, 8: entry delay in cycles from trigger to alarm; minimum 1.
- PISCA_CICLOS, 4: LED half-period in ALARME; used only with ALARME_PISCA_EN.

- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- botoes  in  N_BOTOES  raw asynchronous buttons, 1 = pressed.
- armar  in  1  level, sampled each cycle; arms from DESARMADO.
- desarmar  in  1  level; returns to DESARMADO from any state; beats armar and ack.
- ack  in  1  level; clears a latched alarm.
- contagem  out  $clog2(N_BOTOES+1)  registered popcount of the debounced buttons.
- estado  out  2  0 DESARMADO, 1 ARMADO, 2 PRE_ALARME, 3 ALARME.
- led  out  1  visual indicator (registered).
- sirene  out  1  buzzer, 1 only in ALARME (registered).

## Operation
- Per input: 2-flop synchroniser, then debounce counter (width $clog2(DEB_CICLOS+1)).
  - Counter clears whenever synced == debounced.
  - Otherwise it increments. At DEB_CICLOS it flips the debounced bit and clears.
  - A glitch shorter than DEB_CICLOS cycles never reaches the debounced bit.
- contagem is registered from the sum of the debounced bits and never wraps (max N_BOTOES).
- Trigger condition: contagem >= K_MIN, compared on the registered value.
- FSM, evaluated each edge in priority order (desarmar first):
  - desarmar=1: go to DESARMADO and clear the timer, in every state.
  - DESARMADO: armar=1 -> ARMADO. The trigger condition is ignored.
  - ARMADO: trigger -> PRE_ALARME and load the timer with ATRASO_CICLOS-1. armar is ignored.
  - PRE_ALARME: timer decrements each cycle.
    - At timer==0 -> ALARME.
    - Releasing buttons does not abort the delay; only desarmar does.
  - ALARME: latched. Moves only when ack=1 and the trigger is false -> ARMADO.
    - ack while the trigger is still true is ignored.
- Outputs without the macro:
  - led = 1 in PRE_ALARME and ALARME, else 0.
  - sirene = 1 only in ALARME.
- Reset values:
  - estado=0, contagem=0, led=0, sirene=0.
  - All synchroniser, debounced, debounce-counter and timer registers = 0 (all buttons treated as released).
- Reset asserted mid-operation (any state, including ALARME) returns everything to reset values on that edge. armar/desarmar/ack are ignored while rst=1.

## Timing
- Button path: a stable change on botoes before edge E reaches the debounced bit at edge E+1+DEB_CICLOS.
  - contagem reflects it at edge E+2+DEB_CICLOS.
  - estado leaves ARMADO at edge E+3+DEB_CICLOS.
- PRE_ALARME lasts exactly ATRASO_CICLOS cycles. estado=3 on the following edge.
- led/sirene are registered from the next-state value, so they change on the same edge as estado.
- Control inputs act on the first edge where they are high. No internal edge detection: holding armar after desarmar re-arms one cycle after desarmar drops.

## Configuration
- ALARME_PISCA_EN defined:
  - In ALARME, led toggles every PISCA_CICLOS cycles, starting at 1 on the entry edge.
  - A blink counter of width $clog2(PISCA_CICLOS) is added, cleared on entry to ALARME and on reset.
  - PRE_ALARME keeps led steady at 1.
- ALARME_PISCA_EN undefined:
  - led is steady 1 in ALARME.
  - No blink counter exists and PISCA_CICLOS is unused.

## Test plan
All scenarios use the default parameters.
- Reset, then armar=1 for 1 cycle -> estado=1, led=0, sirene=0. botoes=3'b001 held -> contagem=1, estado stays 1 indefinitely.
- Armed; botoes=3'b011 held -> contagem=2 at E+6, estado=2 at E+7, estado=3 exactly 8 cycles later, sirene=1.
- In ALARME; ack=1 with botoes still 3'b011 -> remains ALARME. Release all, wait for contagem=0, ack=1 -> estado=1, sirene=0, led=0.
- Armed; pulse botoes=3'b111 for 3 cycles only -> contagem stays 0, estado stays 1 (debounce rejects the glitch).
- In PRE_ALARME; desarmar=1 and armar=1 on the same edge -> estado=0, timer cleared. rst=1 while in ALARME -> all outputs 0 on that edge.
- With ALARME_PISCA_EN: in ALARME, led pattern is 1111 0000 1111 over 12 cycles from the entry edge. Without the macro, led is constant 1.
